pq_op_scheduler: RTL and testbench

//  Command front-end placed directly upstream of the RegisterTree priority queue (max-first).

---
 rtl/pq_op_scheduler.sv | 106 ++++++++++
 tb/tb_pq_op_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_op_scheduler.sv
// pq_op_scheduler: command front-end that paces ENQ/DEQ/REPLACE into a max-first priority queue
// Ports:
//   i_CLK, i_RSTn                     clock (rising edge), asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready           command handshake; ready only in IDLE
//   i_cmd_op, i_cmd_data              00 NOP, 01 ENQ, 10 DEQ, 11 REPLACE, and operand
//   o_rsp_valid/i_rsp_ready           popped-head response handshake
//   o_rsp_data                        head value captured at accept
//   o_pq_wrt, o_pq_read, o_pq_data    one-cycle strobes and data to the queue
//   i_pq_full, i_pq_empty, i_pq_data  queue status and current head
//   o_busy                            FSM not in IDLE
//   o_drop_cnt                        saturating count of dropped commands
module pq_op_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int QUEUE_SIZE = 15,
    parameter int ENQ_WAIT   = $clog2(QUEUE_SIZE),
    parameter int DEQ_WAIT   = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [1:0]            i_cmd_op,
    input  logic [DATA_WIDTH-1:0] i_cmd_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_pq_wrt,
    output logic                  o_pq_read,
    output logic [DATA_WIDTH-1:0] o_pq_data,
    input  logic                  i_pq_full,
    input  logic                  i_pq_empty,
    input  logic [DATA_WIDTH-1:0] i_pq_data,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_drop_cnt
);
    localparam int WAIT_MAX = (ENQ_WAIT > DEQ_WAIT) ? ENQ_WAIT : DEQ_WAIT;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [1:0] OP_NOP = 2'b00, OP_ENQ = 2'b01, OP_DEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                r_state, w_next;
    logic [1:0]            r_op;
    logic [DATA_WIDTH-1:0] r_data, r_head;
    logic                  r_pend;
    logic [WAIT_W-1:0]     r_cnt;
    logic [CNT_WIDTH-1:0]  r_drop;
    logic                  w_accept, w_drop, w_go;

    assign w_accept   = i_cmd_valid & o_cmd_ready;
    assign w_drop     = w_accept & (((i_cmd_op == OP_ENQ) & i_pq_full) | ((i_cmd_op == OP_DEQ) & i_pq_empty));
    assign w_go       = w_accept & (i_cmd_op != OP_NOP) & ~w_drop;
    assign o_drop_cnt = r_drop;

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // The wait counter is loaded at accept and runs down through ISSUE as well,
    // so WAIT lasts (load - 1) cycles.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_go ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = (r_cnt == WAIT_W'(1)) ? (r_pend ? S_RESP : S_IDLE) : S_WAIT;
            S_RESP:  w_next = i_rsp_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // op[0] marks a write (ENQ/REPLACE), op[1] a read (DEQ/REPLACE).
    always_comb begin
        o_cmd_ready = (r_state == S_IDLE) & i_RSTn;
        o_busy      = r_state != S_IDLE;
        o_pq_wrt    = (r_state == S_ISSUE) & r_op[0];
        o_pq_read   = (r_state == S_ISSUE) & r_op[1];
        o_pq_data   = o_pq_wrt ? r_data : '0;
        o_rsp_valid = r_state == S_RESP;
        o_rsp_data  = o_rsp_valid ? r_head : '0;
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_op   <= OP_NOP;
            r_data <= '0;
            r_head <= '0;
            r_pend <= 1'b0;
            r_cnt  <= '0;
            r_drop <= '0;
        end else begin
            if (w_go) begin
                r_op   <= i_cmd_op;
                r_data <= i_cmd_data;
                r_head <= i_pq_data;
                r_pend <= i_cmd_op[1] & ~i_pq_empty;
                r_cnt  <= (i_cmd_op == OP_ENQ) ? WAIT_W'(ENQ_WAIT) : WAIT_W'(DEQ_WAIT);
            end else if (r_state == S_ISSUE || r_state == S_WAIT) begin
                r_cnt <= r_cnt - WAIT_W'(1);
            end
            if (w_drop && r_drop != '1) r_drop <= r_drop + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_pq_op_scheduler.sv
// tb_pq_op_scheduler: directed and random stimulus for pq_op_scheduler against a behavioural queue
module tb_pq_op_scheduler;
    logic        i_CLK = 1'b0, i_RSTn = 1'b0;
    logic        i_cmd_valid = 1'b0, i_rsp_ready = 1'b0;
    logic [1:0]  i_cmd_op = 2'b00;
    logic [15:0] i_cmd_data = '0;
    logic        o_cmd_ready, o_rsp_valid, o_pq_wrt, o_pq_read, o_busy;
    logic [15:0] o_rsp_data, o_pq_data, o_drop_cnt;
    logic        pq_full = 1'b0, pq_empty = 1'b1;
    logic [15:0] pq_head = '0;

    int total = 0, bad = 0;
    int pq_q[$];
    int ref_q[$];
    int ref_drop = 0;
    logic [15:0] wrt_log[$];
    int wrt_cnt = 0, rd_cnt = 0, both_cnt = 0, consec = 0;
    bit prev_pulse = 0;

    pq_op_scheduler dut (
        .i_CLK(i_CLK), .i_RSTn(i_RSTn),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(i_cmd_op), .i_cmd_data(i_cmd_data),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
        .o_pq_wrt(o_pq_wrt), .o_pq_read(o_pq_read), .o_pq_data(o_pq_data),
        .i_pq_full(pq_full), .i_pq_empty(pq_empty), .i_pq_data(pq_head),
        .o_busy(o_busy), .o_drop_cnt(o_drop_cnt)
    );

    always #5 i_CLK = ~i_CLK;

    // Downstream queue: settles instantly, head is the largest stored value.
    always @(posedge i_CLK) begin
        if (!i_RSTn) pq_q.delete();
        else if (o_pq_wrt && o_pq_read) begin
            if (pq_q.size() > 0) void'(pq_q.pop_back());
            pq_q.push_back(int'(o_pq_data));
            pq_q.sort();
        end else if (o_pq_wrt) begin
            if (pq_q.size() < 15) begin
                pq_q.push_back(int'(o_pq_data));
                pq_q.sort();
            end
        end else if (o_pq_read) begin
            if (pq_q.size() > 0) void'(pq_q.pop_back());
        end
        if (o_pq_wrt) begin
            wrt_cnt++;
            wrt_log.push_back(o_pq_data);
        end
        if (o_pq_read) rd_cnt++;
        if (o_pq_wrt && o_pq_read) both_cnt++;
        if ((o_pq_wrt || o_pq_read) && prev_pulse) consec++;
        prev_pulse = o_pq_wrt || o_pq_read;
        pq_empty = pq_q.size() == 0;
        pq_full  = pq_q.size() == 15;
        pq_head  = (pq_q.size() > 0) ? 16'(pq_q[$]) : 16'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one command, predict its effect from the reference multiset and check the outcome.
    task automatic send(input logic [1:0] op, input int d, input int hold, output int acc);
        bit exp_drop, exp_rsp, seen;
        int exp_val;
        exp_drop = (op == 2'b01 && ref_q.size() == 15) || (op == 2'b10 && ref_q.size() == 0);
        exp_rsp  = (op == 2'b10 && !exp_drop) || (op == 2'b11 && ref_q.size() > 0);
        exp_val  = exp_rsp ? ref_q[$] : 0;
        if (exp_drop) ref_drop++;
        else if (op == 2'b01) begin
            ref_q.push_back(d & 16'hFFFF);
            ref_q.sort();
        end else if (op == 2'b10) void'(ref_q.pop_back());
        else if (op == 2'b11) begin
            if (ref_q.size() > 0) void'(ref_q.pop_back());
            ref_q.push_back(d & 16'hFFFF);
            ref_q.sort();
        end
        @(negedge i_CLK);
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_data  = 16'(d);
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            if (o_cmd_ready) begin
                @(posedge i_CLK);
                acc = int'($time / 10);
                break;
            end
            @(negedge i_CLK);
        end
        if (acc < 0) chk("accept_timeout", 0, 1);
        #1 i_cmd_valid = 1'b0;
        if (exp_drop) begin
            @(negedge i_CLK);
            chk("drop_cnt", o_drop_cnt, ref_drop);
            chk("drop_ready", o_cmd_ready, 1);
            chk("drop_busy", o_busy, 0);
        end
        if (exp_rsp) begin
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge i_CLK);
                if (o_rsp_valid) begin
                    seen = 1;
                    break;
                end
            end
            chk("rsp_timeout", seen, 1);
            for (int h = 0; h < hold; h++) begin
                chk("rsp_hold_data", o_rsp_data, exp_val);
                chk("rsp_hold_noready", o_cmd_ready, 0);
                @(negedge i_CLK);
                chk("rsp_hold_valid", o_rsp_valid, 1);
            end
            chk("rsp_data", o_rsp_data, exp_val);
            i_rsp_ready = 1'b1;
            @(posedge i_CLK);
            #1 i_rsp_ready = 1'b0;
        end
    endtask

    task automatic settle(input string tag);
        bit seen = 0, ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge i_CLK);
            if (o_rsp_valid) seen = 1;
            if (o_cmd_ready) begin
                ok = 1;
                break;
            end
        end
        chk({tag, "_idle"}, ok, 1);
        chk({tag, "_norsp"}, seen, 0);
    endtask

    initial begin
        int a0, a1, a2, acc, w0, r0;
        // reset held
        repeat (3) @(posedge i_CLK);
        #1;
        chk("rst_ready", o_cmd_ready, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_wrt", o_pq_wrt, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_drop", o_drop_cnt, 0);
        @(negedge i_CLK) i_RSTn = 1'b1;
        @(posedge i_CLK);
        #1 chk("rel_ready", o_cmd_ready, 1);

        // back-to-back enqueues
        send(2'b01, 5, 0, a0);
        send(2'b01, 9, 0, a1);
        send(2'b01, 2, 0, a2);
        chk("enq_space1", a1 - a0, 5);
        chk("enq_space2", a2 - a1, 5);
        settle("enq3");
        chk("wrt_n", wrt_log.size(), 3);
        chk("wrt_d0", wrt_log[0], 5);
        chk("wrt_d1", wrt_log[1], 9);
        chk("wrt_d2", wrt_log[2], 2);
        chk("pulse_width", consec, 0);

        // dequeues, first one with a stalled consumer
        send(2'b10, 0, 3, acc);
        send(2'b10, 0, 0, a0);
        send(2'b10, 0, 0, a1);
        chk("deq_space", a1 - a0, 4);
        chk("deq_reads", rd_cnt, 3);

        // dequeue on empty is dropped
        r0 = rd_cnt;
        send(2'b10, 0, 0, acc);
        settle("deq_empty");
        chk("deq_empty_noread", rd_cnt, r0);
        chk("deq_empty_drop", o_drop_cnt, 1);

        // fill then overflow
        for (int i = 0; i < 15; i++) send(2'b01, $urandom_range(1, 1000), 0, acc);
        settle("fill");
        w0 = wrt_cnt;
        send(2'b01, 100, 0, acc);
        settle("ovf");
        chk("ovf_nowrt", wrt_cnt, w0);
        chk("ovf_drop", o_drop_cnt, 2);
        chk("ovf_head", pq_head, ref_q[$]);
        for (int i = 0; i < 15; i++) send(2'b10, 0, $urandom_range(0, 2), acc);
        settle("drain");

        // replace with and without a head
        send(2'b01, 40, 0, acc);
        w0 = both_cnt;
        send(2'b11, 7, 0, acc);
        chk("rep_both", both_cnt - w0, 1);
        chk("rep_pulse_width", consec, 0);
        send(2'b10, 0, 0, acc);
        send(2'b11, 7, 0, acc);
        settle("rep_empty");
        chk("rep_empty_head", pq_head, 7);
        send(2'b10, 0, 0, acc);

        // random traffic against the reference multiset
        for (int i = 0; i < 120; i++) begin
            send(2'($urandom_range(0, 3)), int'($urandom_range(0, 65535)), $urandom_range(0, 3), acc);
            if ($urandom_range(0, 1) == 1) settle("rnd");
        end
        settle("rnd_end");
        chk("rnd_drop", o_drop_cnt, ref_drop);
        chk("rnd_head", pq_head, (ref_q.size() > 0) ? ref_q[$] : 0);
        chk("rnd_pulse_width", consec, 0);

        // asynchronous reset in the middle of WAIT
        send(2'b01, 11, 0, acc);
        @(posedge i_CLK);
        #2 i_RSTn = 1'b0;
        #1;
        chk("arst_busy", o_busy, 0);
        chk("arst_ready", o_cmd_ready, 0);
        chk("arst_wrt", o_pq_wrt, 0);
        chk("arst_read", o_pq_read, 0);
        chk("arst_pqdata", o_pq_data, 0);
        chk("arst_rsp", o_rsp_valid, 0);
        chk("arst_rspdata", o_rsp_data, 0);
        chk("arst_drop", o_drop_cnt, 0);
        ref_q.delete();
        ref_drop = 0;
        repeat (2) @(posedge i_CLK);
        @(negedge i_CLK) i_RSTn = 1'b1;
        @(posedge i_CLK);
        #1;
        chk("arel_ready", o_cmd_ready, 1);
        chk("arel_drop", o_drop_cnt, 0);
        send(2'b01, 33, 0, acc);
        send(2'b10, 0, 1, acc);
        settle("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
